// File: rtl/adpll_pkg.sv
// Shared constants, parameter indices and sequencer state encoding for the ADPLL configuration slice.
package adpll_pkg;

  localparam int DATA_W     = 5;
  localparam int NUM_PARAMS = 6;
  localparam int PIDX_W     = 3;

  localparam logic [PIDX_W-1:0] PIDX_NDIV       = 3'd0;
  localparam logic [PIDX_W-1:0] PIDX_ALPHA      = 3'd1;
  localparam logic [PIDX_W-1:0] PIDX_BETA       = 3'd2;
  localparam logic [PIDX_W-1:0] PIDX_DCO_OFFSET = 3'd3;
  localparam logic [PIDX_W-1:0] PIDX_DCO_THRESH = 3'd4;
  localparam logic [PIDX_W-1:0] PIDX_KDCO       = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SETUP   = 3'd2,
    ST_PULSE   = 3'd3,
    ST_HOLD    = 3'd4,
    ST_SETTLE  = 3'd5,
    ST_MONITOR = 3'd6
  } seq_state_e;

  // The divider register in the core is only 4 bits wide, so its shadow drops the top bit.
  function automatic logic [DATA_W-1:0] param_mask(input logic [PIDX_W-1:0] idx,
                                                   input logic [DATA_W-1:0] value);
    if (idx == PIDX_NDIV) begin
      return {1'b0, value[3:0]};
    end
    return value;
  endfunction

endpackage

// File: rtl/adpll_lock_det.sv
// Lock detector: counts consecutive small filter outputs and reports lock / loss of lock.
module adpll_lock_det
  import adpll_pkg::*;
#(
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic [DATA_W-1:0] mon_dout,
  input  logic              mon_sign,
  output logic              locked,
  output logic              lock_lost
);

  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0]     CNT_MAX = CW'(LOCK_CNT);
  localparam logic [DATA_W-1:0] TOL     = DATA_W'(LOCK_TOL);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          locked_q, locked_d;
  logic          lost_q, lost_d;
  logic          in_tol;
  logic          unused_sign;

  // Lock is judged on magnitude alone; the sign of the filter output carries no lock information.
  assign unused_sign = mon_sign;
  assign in_tol      = (mon_dout <= TOL);

  // Next-state of the run-length counter and lock flags; disabled or cleared means forget everything silently.
  always_comb begin
    cnt_d    = cnt_q;
    locked_d = locked_q;
    lost_d   = 1'b0;
    if (!enable || clear) begin
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (in_tol) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == CNT_MAX) begin
        locked_d = 1'b1;
      end
    end else begin
      cnt_d = '0;
      if (locked_q) begin
        locked_d = 1'b0;
        lost_d   = 1'b1;
      end
    end
  end

  // Register the detector state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
    end
  end

  assign locked    = locked_q;
  assign lock_lost = lost_q;

endmodule

// File: rtl/adpll_cfg_seq.sv
// Configuration sequencer: shadows the loop parameters, clears and programs the ADPLL core, then watches for lock.
module adpll_cfg_seq
  import adpll_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 2,
  parameter int HOLD_CYC   = 2,
  parameter int SETTLE_CYC = 64,
  parameter int LOCK_TOL   = 2,
  parameter int LOCK_CNT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              start,
  input  logic              abort,
  output logic              clr,
  output logic              pgm,
  output logic [2:0]        param_sel,
  output logic [DATA_W-1:0] pgm_value,
  input  logic [DATA_W-1:0] mon_dout,
  input  logic              mon_sign,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic              lock_lost,
  output logic [2:0]        state_dbg
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PIDX_W-1:0] idx_q, idx_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] shadow_q [NUM_PARAMS];
  logic [DATA_W-1:0] shadow_d [NUM_PARAMS];
  logic              busy_w;
  logic              mon_en;

  // State register together with the phase counter, parameter index and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: each phase lasts a fixed number of cycles, abort overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (start) begin
            state_d = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == PULSE_LAST) begin
            state_d = ST_SETUP;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
        ST_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            state_d = ST_PULSE;
            cnt_d   = '0;
          end
        end
        ST_PULSE: begin
          if (cnt_q == PULSE_LAST) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d = '0;
            if (idx_q == PIDX_KDCO) begin
              state_d = ST_SETTLE;
            end else begin
              state_d = ST_SETUP;
              idx_d   = idx_q + 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_MONITOR;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
        end
        ST_MONITOR: begin
          cnt_d = '0;
          if (start) begin
            state_d = ST_CLEAR;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Output decode: the programming bus only carries a value while a parameter is being written.
  always_comb begin
    clr       = 1'b0;
    pgm       = 1'b0;
    param_sel = '0;
    pgm_value = '0;
    busy_w    = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr    = 1'b1;
        busy_w = 1'b1;
      end
      ST_SETUP, ST_HOLD: begin
        param_sel = idx_q;
        pgm_value = shadow_q[idx_q];
        busy_w    = 1'b1;
      end
      ST_PULSE: begin
        pgm       = 1'b1;
        param_sel = idx_q;
        pgm_value = shadow_q[idx_q];
        busy_w    = 1'b1;
      end
      ST_SETTLE: begin
        busy_w = 1'b1;
      end
      default: begin
        busy_w = 1'b0;
      end
    endcase
  end

  // Shadow updates are refused while busy, which freezes the values being programmed.
  always_comb begin
    for (int i = 0; i < NUM_PARAMS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (cfg_we && !busy_w && (cfg_addr == PIDX_W'(i))) begin
        shadow_d[i] = param_mask(PIDX_W'(i), cfg_wdata);
      end
    end
  end

  // Shadow register bank.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (rst) begin
        shadow_q[i] <= '0;
      end else begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign mon_en    = (state_q == ST_MONITOR);
  assign busy      = busy_w;
  assign done      = done_q;
  assign state_dbg = state_q;

  // Leaving MONITOR by start or abort drops lock quietly, so the detector is cleared on either.
  adpll_lock_det #(
    .LOCK_TOL (LOCK_TOL),
    .LOCK_CNT (LOCK_CNT)
  ) u_lock_det (
    .clk       (clk),
    .rst       (rst),
    .enable    (mon_en),
    .clear     (abort | start),
    .mon_dout  (mon_dout),
    .mon_sign  (mon_sign),
    .locked    (locked),
    .lock_lost (lock_lost)
  );

endmodule

// File: tb/tb_adpll_cfg_seq.sv
// Bench for adpll_cfg_seq: cycle-accurate expectations derived from the sequence timing rules and a lock-run model.
module tb_adpll_cfg_seq;

  localparam int SETUP_C    = 2;
  localparam int PULSE_C    = 2;
  localparam int HOLD_C     = 2;
  localparam int SETTLE_C   = 64;
  localparam int TOL        = 2;
  localparam int LCNT       = 16;
  localparam int NP         = 6;
  localparam int PER        = SETUP_C + PULSE_C + HOLD_C;
  localparam int PROG_START = 1 + PULSE_C;
  localparam int PROG_END   = PROG_START + NP * PER;
  localparam int SETTLE_END = PROG_END + SETTLE_C;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [4:0] cfg_wdata;
  logic       start;
  logic       abort;
  logic       clr;
  logic       pgm;
  logic [2:0] param_sel;
  logic [4:0] pgm_value;
  logic [4:0] mon_dout;
  logic       mon_sign;
  logic       busy;
  logic       done;
  logic       locked;
  logic       lock_lost;
  logic [2:0] state_dbg;

  logic [16:0] obs;
  int          vectors;
  int          miscompares;
  logic [4:0]  model_shadow [NP];
  int          m_cnt;
  logic        m_locked;
  logic        m_lost;

  adpll_cfg_seq #(
    .SETUP_CYC  (SETUP_C),
    .PULSE_CYC  (PULSE_C),
    .HOLD_CYC   (HOLD_C),
    .SETTLE_CYC (SETTLE_C),
    .LOCK_TOL   (TOL),
    .LOCK_CNT   (LCNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .start     (start),
    .abort     (abort),
    .clr       (clr),
    .pgm       (pgm),
    .param_sel (param_sel),
    .pgm_value (pgm_value),
    .mon_dout  (mon_dout),
    .mon_sign  (mon_sign),
    .busy      (busy),
    .done      (done),
    .locked    (locked),
    .lock_lost (lock_lost),
    .state_dbg (state_dbg)
  );

  assign obs = {clr, pgm, param_sel, pgm_value, busy, done, locked, lock_lost, state_dbg};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected output bundle t cycles after start was accepted, from the phase timing rules.
  function automatic logic [16:0] exp_seq(input int t);
    logic       c, p, b, d;
    logic [2:0] sel, st;
    logic [4:0] val;
    int         rel, i, ph;
    c = 1'b0; p = 1'b0; b = 1'b0; d = 1'b0;
    sel = 3'd0; st = 3'd0; val = 5'd0;
    if (t >= 1 && t < PROG_START) begin
      c = 1'b1; b = 1'b1; st = 3'd1;
    end else if (t >= PROG_START && t < PROG_END) begin
      rel = t - PROG_START;
      i   = rel / PER;
      ph  = rel % PER;
      sel = 3'(i);
      val = model_shadow[i];
      b   = 1'b1;
      if (ph < SETUP_C) begin
        st = 3'd2;
      end else if (ph < SETUP_C + PULSE_C) begin
        st = 3'd3;
        p  = 1'b1;
      end else begin
        st = 3'd4;
      end
    end else if (t >= PROG_END && t < SETTLE_END) begin
      b = 1'b1; st = 3'd5;
    end else if (t == SETTLE_END) begin
      d = 1'b1; st = 3'd6;
    end
    return {c, p, sel, val, b, d, 1'b0, 1'b0, st};
  endfunction

  // Shadow write while not busy; the model keeps what a register file with these rules would hold.
  task automatic cfg_write(input logic [2:0] a, input logic [4:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
    if (a <= 3'd5) model_shadow[a] = (a == 3'd0) ? {1'b0, d[3:0]} : d;
  endtask

  // Start a sequence and compare every cycle; optionally stop it with abort or rst at cycle stop_at.
  task automatic run_sequence(input string tag, input int stop_at, input bit stop_rst, input bit poke,
                              input bit wr_start, input logic [2:0] wa, input logic [4:0] wd);
    logic [16:0] expv;
    start = 1'b1;
    if (wr_start) begin
      cfg_we = 1'b1; cfg_addr = wa; cfg_wdata = wd;
      if (wa <= 3'd5) model_shadow[wa] = (wa == 3'd0) ? {1'b0, wd[3:0]} : wd;
    end
    step();
    start = 1'b0;
    cfg_we = 1'b0;
    for (int t = 1; t <= SETTLE_END; t++) begin
      expv = exp_seq(t);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("[TB] FAIL %s t=%0d got=%05h exp=%05h", tag, t, obs, expv);
      end
      if (t == stop_at) begin
        if (stop_rst) rst = 1'b1;
        else abort = 1'b1;
        step();
        rst = 1'b0;
        abort = 1'b0;
        if (stop_rst) begin
          for (int k = 0; k < NP; k++) model_shadow[k] = 5'd0;
        end
        vectors++;
        if (obs !== 17'h0) begin
          miscompares++;
          $display("[TB] FAIL %s_stop got=%05h exp=%05h", tag, obs, 17'h0);
        end
        return;
      end
      if (t < SETTLE_END) begin
        mon_dout = 5'($urandom);
        mon_sign = 1'($urandom);
        if (poke) begin
          cfg_we    = 1'($urandom);
          cfg_addr  = 3'($urandom);
          cfg_wdata = 5'($urandom);
          if (t == 10) begin
            cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 5'd31;
          end
        end
        step();
        cfg_we = 1'b0;
      end
    end
  endtask

  // One monitor sample against the run-length lock model.
  task automatic lock_sample(input logic [4:0] d, input logic s, input string tag);
    mon_dout = d; mon_sign = s;
    step();
    if (d <= 5'(TOL)) begin
      m_lost = 1'b0;
      if (m_cnt < LCNT) m_cnt++;
      if (m_cnt >= LCNT) m_locked = 1'b1;
    end else begin
      m_lost   = m_locked;
      m_locked = 1'b0;
      m_cnt    = 0;
    end
    vectors++;
    if ({done, locked, lock_lost, state_dbg} !== {1'b0, m_locked, m_lost, 3'd6}) begin
      miscompares++;
      $display("[TB] FAIL %s got=%b_%b_%b_%0d exp=0_%b_%b_6", tag, done, locked, lock_lost, state_dbg,
               m_locked, m_lost);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cfg_we = 1'($urandom); cfg_addr = 3'($urandom); cfg_wdata = 5'($urandom);
      start = 1'($urandom); abort = 1'($urandom);
      mon_dout = 5'($urandom); mon_sign = 1'($urandom);
      step();
      vectors++;
      if (obs !== 17'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_hold got=%05h exp=%05h", obs, 17'h0);
      end
    end
    cfg_we = 1'b0; start = 1'b0; abort = 1'b0; rst = 1'b0;
    step();
    vectors++;
    if (obs !== 17'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_release got=%05h exp=%05h", obs, 17'h0);
    end
    for (int k = 0; k < NP; k++) model_shadow[k] = 5'd0;
  endtask

  task automatic test_program_sequence();
    cfg_write(3'd0, 5'd4);
    cfg_write(3'd1, 5'd3);
    cfg_write(3'd2, 5'd5);
    cfg_write(3'd3, 5'd2);
    cfg_write(3'd4, 5'd10);
    cfg_write(3'd5, 5'd1);
    run_sequence("plan_prog", 0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
    mon_dout = 5'd31;
    for (int k = 0; k < NP; k++) cfg_write(3'(k), 5'($urandom));
    run_sequence("random_prog", 0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
  endtask

  task automatic test_lock();
    m_cnt = 0; m_locked = 1'b0; m_lost = 1'b0;
    for (int i = 0; i < 16; i++) lock_sample(5'd1, 1'($urandom), "lock_run");
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL lock_after_16 got=%b exp=1", locked);
    end
    lock_sample(5'd7, 1'b0, "lock_loss");
    vectors++;
    if ({locked, lock_lost} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL lock_lost_pulse got=%b%b exp=01", locked, lock_lost);
    end
    lock_sample(5'd0, 1'b1, "lost_one_cycle");
    for (int i = 0; i < 14; i++) lock_sample(5'($urandom_range(0, 2)), 1'($urandom), "restart_a");
    lock_sample(5'd3, 1'b0, "restart_break");
    for (int i = 0; i < 15; i++) lock_sample(5'($urandom_range(0, 2)), 1'($urandom), "restart_b");
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lock_restart got=%b exp=0", locked);
    end
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) lock_sample(5'($urandom_range(3, 31)), 1'($urandom), "lock_random");
      else lock_sample(5'($urandom_range(0, 2)), 1'($urandom), "lock_random");
    end
  endtask

  task automatic test_abort();
    run_sequence("abort_pulse", PROG_START + 2 * PER + SETUP_C, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (obs !== 17'h0) begin
        miscompares++;
        $display("[TB] FAIL idle_after_abort got=%05h exp=%05h", obs, 17'h0);
      end
    end
    run_sequence("after_abort", 0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
    m_cnt = 0; m_locked = 1'b0; m_lost = 1'b0;
    for (int i = 0; i < 17; i++) lock_sample(5'd0, 1'($urandom), "abort_lockup");
    mon_dout = 5'd31;
    abort = 1'b1;
    step();
    abort = 1'b0;
    vectors++;
    if (obs !== 17'h0) begin
      miscompares++;
      $display("[TB] FAIL abort_monitor got=%05h exp=%05h", obs, 17'h0);
    end
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    vectors++;
    if (obs !== 17'h0) begin
      miscompares++;
      $display("[TB] FAIL abort_beats_start got=%05h exp=%05h", obs, 17'h0);
    end
  endtask

  task automatic test_busy_write();
    run_sequence("busy_write", 0, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    vectors++;
    if (obs !== 17'h0) begin
      miscompares++;
      $display("[TB] FAIL busy_write_abort got=%05h exp=%05h", obs, 17'h0);
    end
    cfg_write(3'd6, 5'($urandom));
    cfg_write(3'd7, 5'($urandom));
    run_sequence("after_busy_write", 0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
  endtask

  task automatic test_back_to_back();
    mon_dout = 5'd31;
    cfg_write(3'd0, 5'($urandom) | 5'h10);
    for (int k = 1; k < NP; k++) cfg_write(3'(k), 5'($urandom));
    m_cnt = 0; m_locked = 1'b0; m_lost = 1'b0;
    for (int i = 0; i < 16; i++) lock_sample(5'($urandom_range(0, 2)), 1'($urandom), "b2b_lockup");
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_locked got=%b exp=1", locked);
    end
    run_sequence("restart_locked", 0, 1'b0, 1'b0, 1'b1, 3'd0, 5'h15);
    run_sequence("back_to_back", 0, 1'b0, 1'b0, 1'b1, 3'd4, 5'($urandom));
  endtask

  task automatic test_reset_mid_settle();
    run_sequence("rst_settle", PROG_END + 31, 1'b1, 1'b0, 1'b0, 3'd0, 5'd0);
    run_sequence("after_reset", 0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 5'd0;
    start = 1'b0; abort = 1'b0; mon_dout = 5'd0; mon_sign = 1'b0;
    m_cnt = 0; m_locked = 1'b0; m_lost = 1'b0;
    for (int k = 0; k < NP; k++) model_shadow[k] = 5'd0;
    $display("[TB] starting adpll_cfg_seq bench");
    test_reset();
    test_program_sequence();
    test_lock();
    test_abort();
    test_busy_write();
    test_back_to_back();
    test_reset_mid_settle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
